moesi_coherency_bus: RTL and testbench



---
 rtl/moesi_pkg.sv | 24 ++
 rtl/moesi_rr_arbiter.sv | 39 +++
 rtl/moesi_coherency_bus.sv | 121 ++++++++++++
 tb/tb_moesi_coherency_bus.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/moesi_pkg.sv
// Shared definitions for the MOESI snooping bus.
// Contents:
//   - bus transaction type encodings (these pass through the bus unmodified)
//   - core-side request encodings
//   - bus controller FSM state type
package moesi_pkg;

  // Bus transaction types.
  localparam logic [1:0] BUS_RD   = 2'b00;
  localparam logic [1:0] BUS_RDX  = 2'b01;
  localparam logic [1:0] BUS_UPGR = 2'b10;
  localparam logic [1:0] BUS_WB   = 2'b11;

  // Core request kinds.
  localparam logic [1:0] REQ_READ  = 2'b01;
  localparam logic [1:0] REQ_WRITE = 2'b10;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StBcast = 2'b01,
    StHold  = 2'b10
  } bus_state_e;

endpackage

// File: rtl/moesi_rr_arbiter.sv
// Combinational round-robin picker.
// The search starts at last_grant+1 and wraps modulo NUM_CORES, so the core
// that was granted most recently has the lowest priority.
// Ports:
//   req        in  NUM_CORES  request vector
//   last_grant in  GRANT_W    index of the previous winner
//   winner     out GRANT_W    selected index (0 when nothing is requesting)
//   any_valid  out 1          at least one request is pending
module moesi_rr_arbiter
  import moesi_pkg::*;
#(
  parameter int unsigned NUM_CORES = 4,
  localparam int unsigned GRANT_W  = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [GRANT_W-1:0]   last_grant,
  output logic [GRANT_W-1:0]   winner,
  output logic                 any_valid
);

  always_comb begin
    int unsigned        sum;
    logic [GRANT_W-1:0] idx;
    winner    = '0;
    any_valid = 1'b0;
    sum       = 0;
    idx       = '0;
    // The first hit along the rotated order wins.
    for (int unsigned i = 1; i <= NUM_CORES; i++) begin
      sum = 32'(last_grant) + i;
      idx = GRANT_W'(sum % NUM_CORES);
      if (!any_valid && req[idx]) begin
        any_valid = 1'b1;
        winner    = idx;
      end
    end
  end

endmodule

// File: rtl/moesi_coherency_bus.sv
// Snooping-bus arbiter and broadcaster for a multi-core MOESI system.
// Each cache controller raises one request. A round-robin pick chooses the
// winner. The winner's address and type are broadcast for one cycle
// (bus_valid). The grant then stays frozen for HOLD_CYCLES cycles, so the
// memory response can be routed back using granted_core_id.
// Optional build macro: MOESI_BUS_SHARED_EN adds the bus_shared output.
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   core_req_valid   per-core request pending (held until granted)
//   core_req_type    per-core transaction type
//   core_req_addr    per-core line address
//   bus_valid        one-cycle broadcast strobe / memory request valid
//   bus_addr         broadcast address
//   bus_type         broadcast transaction type
//   granted_core_id  current/last granted core
//   bus_shared       (MOESI_BUS_SHARED_EN only) some snooper hit this transaction
//   snoop_resp       per-cache snoop hit
module moesi_coherency_bus
  import moesi_pkg::*;
#(
  parameter int unsigned NUM_CORES   = 4,
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned HOLD_CYCLES = 6,
  localparam int unsigned GRANT_W    = $clog2(NUM_CORES)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_CORES-1:0]                 core_req_valid,
  input  logic [NUM_CORES-1:0][1:0]            core_req_type,
  input  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0] core_req_addr,
  output logic                                 bus_valid,
  output logic [ADDR_WIDTH-1:0]                bus_addr,
  output logic [1:0]                           bus_type,
  output logic [GRANT_W-1:0]                   granted_core_id,
`ifdef MOESI_BUS_SHARED_EN
  output logic                                 bus_shared,
`endif
  input  logic [NUM_CORES-1:0]                 snoop_resp
);

  localparam int unsigned CntW = $clog2(HOLD_CYCLES + 1);

  bus_state_e         state;
  logic [CntW-1:0]    hold_cnt;
  logic [GRANT_W-1:0] rr_last;
  logic [GRANT_W-1:0] arb_winner;
  logic               arb_any;

  moesi_rr_arbiter #(
    .NUM_CORES (NUM_CORES)
  ) u_arb (
    .req        (core_req_valid),
    .last_grant (rr_last),
    .winner     (arb_winner),
    .any_valid  (arb_any)
  );

  // rr_last resets to the top index, so core 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= StIdle;
      hold_cnt        <= '0;
      rr_last         <= GRANT_W'(NUM_CORES - 1);
      bus_valid       <= 1'b0;
      bus_addr        <= '0;
      bus_type        <= '0;
      granted_core_id <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          bus_valid <= 1'b0;
          if (arb_any) begin
            bus_valid       <= 1'b1;
            bus_addr        <= core_req_addr[arb_winner];
            bus_type        <= core_req_type[arb_winner];
            granted_core_id <= arb_winner;
            rr_last         <= arb_winner;
            state           <= StBcast;
          end
        end
        StBcast: begin
          bus_valid <= 1'b0;
          hold_cnt  <= CntW'(HOLD_CYCLES);
          state     <= StHold;
        end
        StHold: begin
          // Requests are ignored here. The grant fields stay frozen.
          hold_cnt <= hold_cnt - CntW'(1);
          if (hold_cnt == CntW'(1)) begin
            state <= StIdle;
          end
        end
        default: begin
          bus_valid <= 1'b0;
          state     <= StIdle;
        end
      endcase
    end
  end

`ifdef MOESI_BUS_SHARED_EN
  // The flag is cleared when a new broadcast starts. Any snoop hit during
  // the BCAST or HOLD cycles sets it, and it then stays set until the next
  // broadcast.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_shared <= 1'b0;
    end else if (state == StIdle) begin
      if (arb_any) begin
        bus_shared <= 1'b0;
      end
    end else if ((state == StBcast || state == StHold) && |snoop_resp) begin
      bus_shared <= 1'b1;
    end
  end
`else
  logic unused_snoop;
  assign unused_snoop = ^snoop_resp;
`endif

endmodule

// File: tb/tb_moesi_coherency_bus.sv
module tb_moesi_coherency_bus;
  localparam int NC   = 4;
  localparam int AW   = 64;
  localparam int HOLD = 6;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NC-1:0]          core_req_valid;
  logic [NC-1:0][1:0]     core_req_type;
  logic [NC-1:0][AW-1:0]  core_req_addr;
  logic                   bus_valid;
  logic [AW-1:0]          bus_addr;
  logic [1:0]             bus_type;
  logic [1:0]             granted_core_id;
  logic [NC-1:0]          snoop_resp;
`ifdef MOESI_BUS_SHARED_EN
  logic                   bus_shared;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  moesi_coherency_bus #(
    .NUM_CORES   (NC),
    .ADDR_WIDTH  (AW),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .core_req_valid  (core_req_valid),
    .core_req_type   (core_req_type),
    .core_req_addr   (core_req_addr),
    .bus_valid       (bus_valid),
    .bus_addr        (bus_addr),
    .bus_type        (bus_type),
    .granted_core_id (granted_core_id),
`ifdef MOESI_BUS_SHARED_EN
    .bus_shared      (bus_shared),
`endif
    .snoop_resp      (snoop_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset(input bit do_check);
    rst_n          = 1'b0;
    core_req_valid = 4'($urandom);
    core_req_type  = 8'($urandom);
    core_req_addr  = '0;
    snoop_resp     = 4'($urandom);
    repeat (3) tick();
    if (do_check) begin
      check("reset_valid", 128'(bus_valid), 128'(0));
      check("reset_addr", 128'(bus_addr), 128'(0));
      check("reset_type", 128'(bus_type), 128'(0));
      check("reset_gid", 128'(granted_core_id), 128'(0));
    end
    rst_n          = 1'b1;
    core_req_valid = '0;
    snoop_resp     = '0;
    tick();
  endtask

  function automatic logic [AW-1:0] vec_addr(input int tag, input int c);
    return 64'h1000_0000 + 64'(tag * 256 + c * 16);
  endfunction

  function automatic logic [1:0] vec_type(input int tag, input int c);
    return 2'(c ^ tag);
  endfunction

  task automatic set_reqs(input logic [NC-1:0] mask, input int tag);
    for (int c = 0; c < NC; c++) begin
      core_req_type[c] = vec_type(tag, c);
      core_req_addr[c] = vec_addr(tag, c);
    end
    core_req_valid = mask;
  endtask

  typedef struct {
    logic [NC-1:0] mask;
    int            exp_gid;
  } vec_t;

  vec_t vecs[8];

  // Random-phase reference model state.
  int            m_last;
  int            m_wait;
  logic          e_valid;
  logic [1:0]    e_gid;
  logic [1:0]    e_type;
  logic [AW-1:0] e_addr;
  logic [NC-1:0] pending;
  int            skips[NC];

  initial begin
    int g[4];
    int t[4];
    int ng;

    // Each expected winner follows from the previous one (reset leaves
    // rr_last = 3).
    vecs[0] = '{4'b0001, 0};
    vecs[1] = '{4'b1111, 1};
    vecs[2] = '{4'b1001, 3};
    vecs[3] = '{4'b1001, 0};
    vecs[4] = '{4'b0001, 0};
    vecs[5] = '{4'b1100, 2};
    vecs[6] = '{4'b0011, 0};
    vecs[7] = '{4'b1010, 1};

    apply_reset(1'b1);

    // Table-driven arbitration vectors.
    for (int i = 0; i < 8; i++) begin
      set_reqs(vecs[i].mask, i + 1);
      tick();
      check($sformatf("vec%0d_valid", i), 128'(bus_valid), 128'(1));
      check($sformatf("vec%0d_gid", i), 128'(granted_core_id), 128'(vecs[i].exp_gid));
      check($sformatf("vec%0d_addr", i), 128'(bus_addr), 128'(vec_addr(i + 1, vecs[i].exp_gid)));
      check($sformatf("vec%0d_type", i), 128'(bus_type), 128'(vec_type(i + 1, vecs[i].exp_gid)));
      core_req_valid = '0;
      tick();
      check($sformatf("vec%0d_pulse_end", i), 128'(bus_valid), 128'(0));
      repeat (6) tick();
    end

    // Single request from core 2.
    core_req_valid    = '0;
    core_req_type[2]  = 2'b01;
    core_req_addr[2]  = 64'h1000;
    core_req_valid[2] = 1'b1;
    check("single_pre", 128'(bus_valid), 128'(0));
    tick();
    check("single_valid", 128'(bus_valid), 128'(1));
    check("single_fields", {granted_core_id, bus_type, bus_addr}, {2'd2, 2'b01, 64'h1000});
    core_req_valid = '0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("single_hold%0d_valid", k), 128'(bus_valid), 128'(0));
      check($sformatf("single_hold%0d_fields", k), {granted_core_id, bus_type, bus_addr},
            {2'd2, 2'b01, 64'h1000});
    end

    // All cores request. Each drops its request once granted.
    apply_reset(1'b0);
    set_reqs(4'b1111, 9);
    ng = 0;
    for (int k = 0; k < 60 && ng < 4; k++) begin
      tick();
      if (bus_valid) begin
        g[ng] = int'(granted_core_id);
        t[ng] = cyc;
        core_req_valid[granted_core_id] = 1'b0;
        ng++;
      end
    end
    check("all4_count", 128'(ng), 128'(4));
    for (int i = 0; i < ng; i++) check($sformatf("all4_order%0d", i), 128'(g[i]), 128'(i));
    for (int i = 1; i < ng; i++) check($sformatf("all4_gap%0d", i), 128'(t[i] - t[i-1]), 128'(8));

    // Cores 1 and 3 request continuously.
    apply_reset(1'b0);
    set_reqs(4'b1010, 10);
    ng = 0;
    for (int k = 0; k < 60 && ng < 4; k++) begin
      tick();
      if (bus_valid) begin
        g[ng] = int'(granted_core_id);
        ng++;
      end
    end
    core_req_valid = '0;
    check("pair_count", 128'(ng), 128'(4));
    for (int i = 0; i < ng; i++) check($sformatf("pair_order%0d", i), 128'(g[i]), 128'((i % 2) ? 3 : 1));

    // Asynchronous reset in the third HOLD cycle.
    apply_reset(1'b0);
    set_reqs(4'b0010, 2);
    tick();
    check("areset_bcast", 128'(bus_valid), 128'(1));
    core_req_valid = '0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("areset_now", {bus_valid, granted_core_id, bus_type, bus_addr}, 128'(0));
    tick();
    rst_n = 1'b1;
    set_reqs(4'b1001, 5);
    tick();
    check("areset_after", {bus_valid, granted_core_id}, {1'b1, 2'd0});
    core_req_valid = '0;
    repeat (8) tick();

`ifdef MOESI_BUS_SHARED_EN
    apply_reset(1'b0);
    set_reqs(4'b0010, 3);
    tick();
    check("shared_bcast", 128'(bus_shared), 128'(0));
    core_req_valid = '0;
    repeat (2) tick();
    snoop_resp = 4'b0100;
    tick();
    snoop_resp = '0;
    check("shared_set", 128'(bus_shared), 128'(1));
    repeat (4) tick();
    check("shared_kept", 128'(bus_shared), 128'(1));
    set_reqs(4'b0001, 4);
    tick();
    check("shared_clear", 128'(bus_shared), 128'(0));
    core_req_valid = '0;
    repeat (7) tick();
    check("shared_stay0", 128'(bus_shared), 128'(0));
`endif

    // Randomized traffic against a transaction-level model.
    apply_reset(1'b0);
    m_last  = NC - 1;
    m_wait  = 0;
    e_valid = 1'b0;
    e_gid   = '0;
    e_type  = '0;
    e_addr  = '0;
    pending = '0;
    for (int c = 0; c < NC; c++) skips[c] = 0;
    for (int k = 0; k < 400; k++) begin
      check("rand_out", {bus_valid, granted_core_id, bus_type, bus_addr},
            {e_valid, e_gid, e_type, e_addr});
      if (e_valid) pending[e_gid] = 1'b0;
      for (int c = 0; c < NC; c++) begin
        if (!pending[c]) begin
          core_req_type[c] = 2'($urandom);
          core_req_addr[c] = {$urandom, $urandom};
          if ($urandom_range(3) == 0) begin
            pending[c] = 1'b1;
            skips[c]   = 0;
          end
        end
      end
      core_req_valid = pending;
      snoop_resp     = 4'($urandom);
      @(posedge clk);
      if (m_wait > 0) begin
        m_wait--;
        e_valid = 1'b0;
      end else if (|pending) begin
        int w;
        w = -1;
        for (int j = 1; j <= NC && w < 0; j++) begin
          if (pending[(m_last + j) % NC]) w = (m_last + j) % NC;
        end
        check("rand_no_starve", 128'(skips[w] < NC), 128'(1));
        for (int c = 0; c < NC; c++) if (pending[c] && c != w) skips[c]++;
        e_valid = 1'b1;
        e_gid   = 2'(w);
        e_type  = core_req_type[w];
        e_addr  = core_req_addr[w];
        m_last  = w;
        m_wait  = HOLD + 1;
      end else begin
        e_valid = 1'b0;
      end
      #1;
      cyc++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
